pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage of the single-cycle RV32I core. Holds the current PC that addresses the instruction memory, computes the next PC each cycle (sequential, taken branch, JAL, JALR), and supplies PC+4 for link-register writeback. A small run-control state machine stops fetch on a halt request or a fault (misaligned or out-of-range target), and a retired-instruction counter tracks progress.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ROM_BYTES, 128, size of instruction memory in bytes; valid fetch addresses are 0 .. ROM_BYTES-4

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- stall  input  1  hold PC this cycle; no retire
- pc_src  input  2  00 sequential, 01 conditional branch, 10 JAL, 11 JALR
- branch_taken  input  1  branch comparison result, used only when pc_src=01
- imm  input  32  sign-extended immediate from decode
- rs1_val  input  32  rs1 register value, used only for JALR
- halt_req  input  1  ECALL/EBREAK decoded in the current instruction
- cur_pc  output  32  PC of the instruction being executed; drives instruction memory address
- pc_plus4  output  32  cur_pc+4, combinational, link value for JAL/JALR
- next_pc  output  32  combinational candidate target for this cycle
- state  output  2  00 RUN, 01 HALT, 10 FAULT
- fault  output  1  high while state=FAULT
- fault_pc  output  32  PC of the instruction whose target faulted; 0 until a fault occurs
- instret  output  32  count of retired instructions

## Operation
- Target selection, combinational, all arithmetic is 32-bit modulo 2^32:
  - pc_src=00: next_pc = cur_pc+4.
  - pc_src=01: next_pc = cur_pc+imm if branch_taken, otherwise cur_pc+4.
  - pc_src=10: next_pc = cur_pc+imm.
  - pc_src=11: next_pc = (rs1_val+imm) with bit 0 cleared.
- A target is bad if next_pc[1:0]!=0, or if next_pc > ROM_BYTES-4 (unsigned compare).
- State machine has three states, RUN, HALT and FAULT. HALT and FAULT are absorbing; only rst leaves them.
- Each rising edge is resolved in this priority order:
  1. rst: cur_pc=RESET_PC, state=RUN, instret=0, fault_pc=0.
  2. state!=RUN: all registers hold.
  3. stall: all registers hold; halt_req and bad targets are ignored this cycle.
  4. halt_req: state becomes HALT; cur_pc holds; instret increments, because ECALL retires.
  5. Bad target: state becomes FAULT; fault_pc=cur_pc; cur_pc holds; instret does not increment.
  6. Otherwise: cur_pc=next_pc and instret increments.
- instret wraps from 32'hFFFF_FFFF to 0 without any flag.
- fault is decoded from state, not registered separately.

## Timing
- Reset values: cur_pc=RESET_PC, state=00, fault=0, fault_pc=0, instret=0. pc_plus4 and next_pc follow from cur_pc.
- Latency is one cycle: the target computed in cycle N appears on cur_pc after edge N. Instruction memory output for the new PC is valid in the same cycle (asynchronous read).
- State changes take effect at the edge. fault and state are valid immediately after it.
- If rst is asserted mid-operation, including in HALT or FAULT, the reset values above apply at the next edge.
- stall asserted together with halt_req or a bad target: stall wins, nothing is recorded, and the event is re-evaluated when stall deasserts.
- halt_req together with a bad target: halt wins and the state goes to HALT, not FAULT.
- Inputs are sampled only at the rising edge. No combinational path exists from inputs to cur_pc.

## Test plan
- Reset then 4 cycles with pc_src=00, no stall: cur_pc steps 0,4,8,12,16; instret=4; state=RUN.
- At cur_pc=8, pc_src=01, imm=-8: with branch_taken=1 the next cur_pc=0; with branch_taken=0 the next cur_pc=12. Each case increments instret by 1.
- At cur_pc=16, pc_src=11, rs1_val=33, imm=0: target is 32, next cur_pc=32. With rs1_val=34: target is 34 (misaligned), so state=FAULT, fault_pc=16, cur_pc stays 16, instret unchanged. Further inputs are ignored until rst.
- At cur_pc=120, pc_src=00: target 124 is accepted. Then at 124, pc_src=00: target 128 exceeds ROM_BYTES-4, so state=FAULT and fault_pc=124.
- stall high for 3 cycles with halt_req=1 at cur_pc=20: cur_pc stays 20, state stays RUN, instret is unchanged. Stall drops: state=HALT, instret+1, cur_pc stays 20.
- rst asserted while in HALT with instret=7: after one edge cur_pc=0, state=RUN, instret=0, fault_pc=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter, target select, run control
// and retired-instruction counter for the RV32I core.
module pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_BYTES = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic [1:0]  i_pc_src,
    input  logic        i_branch_taken,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_val,
    input  logic        i_halt_req,
    output logic [31:0] o_cur_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc,
    output logic [1:0]  o_state,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_instret
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_HALT  = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JAL = 2'b10;
    localparam logic [1:0] SRC_JR  = 2'b11;

    localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic [31:0] r_fault_pc;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [31:0] w_plus4;
    logic [31:0] w_rel_tgt;
    logic [31:0] w_jr_sum;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_next;
    logic        w_misalign;
    logic        w_range;
    logic        w_bad;
    logic        w_run;
    logic        w_adv;
    logic        w_do_halt;
    logic        w_do_fault;
    logic        w_do_step;
    logic        w_retire;

    // Candidate targets; JALR clears bit 0 of its sum.
    assign w_plus4   = r_pc + 32'd4;
    assign w_rel_tgt = r_pc + i_imm;
    assign w_jr_sum  = i_rs1_val + i_imm;
    assign w_jr_tgt  = {w_jr_sum[31:1], 1'b0};

    // Pick the next PC from the control-flow source.
    always_comb begin
        w_next = w_plus4;
        unique case (i_pc_src)
            SRC_SEQ: w_next = w_plus4;
            SRC_BR:  w_next = i_branch_taken ? w_rel_tgt
                                             : w_plus4;
            SRC_JAL: w_next = w_rel_tgt;
            SRC_JR:  w_next = w_jr_tgt;
            default: w_next = w_plus4;
        endcase
    end

    // A target must be word aligned and inside the ROM.
    assign w_misalign = (w_next[1:0] != 2'b00);
    assign w_range    = (w_next > LAST_PC);
    assign w_bad      = w_misalign | w_range;

    // Event decode: stall masks everything, halt beats fault.
    assign w_run      = (r_state == ST_RUN);
    assign w_adv      = w_run & ~i_stall;
    assign w_do_halt  = w_adv & i_halt_req;
    assign w_do_fault = w_adv & ~i_halt_req & w_bad;
    assign w_do_step  = w_adv & ~i_halt_req & ~w_bad;
    assign w_retire   = w_do_halt | w_do_step;

    // Run-control state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run-control next state; HALT and FAULT are absorbing.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_do_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (w_do_fault) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_FAULT;
        endcase
    end

    // Run-control outputs decoded from the current state.
    always_comb begin
        o_state = r_state;
        o_fault = (r_state == ST_FAULT);
    end

    // PC register advances only on a clean retire.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (w_do_step) begin
            r_pc <= w_next;
        end
    end

    // Retired counter; ECALL/EBREAK also retire.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    // Capture the PC of the instruction whose target faulted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fault_pc <= 32'd0;
        end else if (w_do_fault) begin
            r_fault_pc <= r_pc;
        end
    end

    assign o_cur_pc   = r_pc;
    assign o_pc_plus4 = w_plus4;
    assign o_next_pc  = w_next;
    assign o_fault_pc = r_fault_pc;
    assign o_instret  = r_instret;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit target select,
// run control, fault capture and retire counting.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic        br_tk;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        halt;
    logic [31:0] cur_pc;
    logic [31:0] plus4;
    logic [31:0] nxt;
    logic [1:0]  st;
    logic        flt;
    logic [31:0] flt_pc;
    logic [31:0] iret;

    int errors = 0;
    int checks = 0;

    pc_unit #(
        .RESET_PC  (32'h0),
        .ROM_BYTES (128)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_pc_src       (pc_src),
        .i_branch_taken (br_tk),
        .i_imm          (imm),
        .i_rs1_val      (rs1),
        .i_halt_req     (halt),
        .o_cur_pc       (cur_pc),
        .o_pc_plus4     (plus4),
        .o_next_pc      (nxt),
        .o_state        (st),
        .o_fault        (flt),
        .o_fault_pc     (flt_pc),
        .o_instret      (iret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall  = 1'b0;
        pc_src = 2'b00;
        br_tk  = 1'b0;
        imm    = 32'd0;
        rs1    = 32'd0;
        halt   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all(input string tag,
                           input logic [31:0] pc,
                           input logic [1:0]  s,
                           input logic [31:0] fpc,
                           input logic [31:0] n);
        chk({tag, ".pc"}, cur_pc, pc);
        chk({tag, ".st"}, 32'(st), 32'(s));
        chk({tag, ".flt"}, 32'(flt),
            32'(s == 2'b10));
        chk({tag, ".fpc"}, flt_pc, fpc);
        chk({tag, ".ret"}, iret, n);
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // reset values
        do_reset();
        chk_all("rst", 32'd0, 2'b00, 32'd0, 32'd0);
        chk("rst.p4", plus4, 32'd4);
        chk("rst.nx", nxt, 32'd4);

        // sequential fetch 0,4,8,12,16
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq.pc", cur_pc, 32'(4 * i));
        end
        chk_all("seq", 32'd16, 2'b00, 32'd0, 32'd4);

        // branch at 8, imm=-8, taken then not taken
        do_reset();
        step();
        step();
        chk("br.at8", cur_pc, 32'd8);
        pc_src = 2'b01;
        imm    = 32'hFFFF_FFF8;
        br_tk  = 1'b1;
        #1;
        chk("br.tk.nx", nxt, 32'd0);
        step();
        chk_all("br.tk", 32'd0, 2'b00, 32'd0, 32'd3);
        idle();
        step();
        step();
        chk("br.at8b", cur_pc, 32'd8);
        pc_src = 2'b01;
        imm    = 32'hFFFF_FFF8;
        br_tk  = 1'b0;
        #1;
        chk("br.nt.nx", nxt, 32'd12);
        step();
        chk_all("br.nt", 32'd12, 2'b00, 32'd0, 32'd6);

        // JALR at 16: rs1=33 -> 32; then misaligned 34
        do_reset();
        repeat (4) step();
        pc_src = 2'b11;
        rs1    = 32'd33;
        imm    = 32'd0;
        #1;
        chk("jr.nx", nxt, 32'd32);
        step();
        chk_all("jr", 32'd32, 2'b00, 32'd0, 32'd5);
        rs1 = 32'd16;
        step();
        chk("jr.back", cur_pc, 32'd16);
        rs1 = 32'd34;
        #1;
        chk("jr.mis.nx", nxt, 32'd34);
        step();
        chk_all("jr.mis", 32'd16, 2'b10, 32'd16, 32'd6);
        chk("jr.p4", plus4, 32'd20);
        // FAULT absorbs halts and good targets
        pc_src = 2'b00;
        halt   = 1'b1;
        step();
        halt = 1'b0;
        step();
        chk_all("flt.hold", 32'd16, 2'b10, 32'd16, 32'd6);

        // range limit: 124 ok, 128 faults
        do_reset();
        pc_src = 2'b10;
        imm    = 32'd120;
        step();
        chk("rg.120", cur_pc, 32'd120);
        idle();
        step();
        chk_all("rg.124", 32'd124, 2'b00, 32'd0, 32'd2);
        // stall masks the bad target
        stall = 1'b1;
        step();
        chk_all("rg.stl", 32'd124, 2'b00, 32'd0, 32'd2);
        stall = 1'b0;
        step();
        chk_all("rg.128", 32'd124, 2'b10, 32'd124, 32'd2);

        // halt beats a bad target at 124
        do_reset();
        pc_src = 2'b10;
        imm    = 32'd124;
        step();
        idle();
        halt = 1'b1;
        step();
        chk_all("hb", 32'd124, 2'b01, 32'd0, 32'd2);

        // stall with halt for 3 cycles at 20
        do_reset();
        pc_src = 2'b10;
        imm    = 32'd20;
        step();
        idle();
        stall = 1'b1;
        halt  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stl", 32'd20, 2'b00, 32'd0, 32'd1);
        end
        stall = 1'b0;
        step();
        chk_all("stl.h", 32'd20, 2'b01, 32'd0, 32'd2);

        // reset out of HALT with instret=7
        do_reset();
        repeat (6) step();
        halt = 1'b1;
        step();
        chk_all("h7", 32'd24, 2'b01, 32'd0, 32'd7);
        halt = 1'b0;
        step();
        chk_all("h7.hold", 32'd24, 2'b01, 32'd0, 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("h7.rst", 32'd0, 2'b00, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1);
    end

endmodule
